// File: rtl/serial_compare_pkg.sv
// serial_compare_pkg: shared state encodings, result codes and bit-relation type
package serial_compare_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  typedef logic [2:0] res_t;
  localparam res_t RES_GT = 3'b100;
  localparam res_t RES_EQ = 3'b010;
  localparam res_t RES_LT = 3'b001;
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } rel_t;
  // Maps the sticky decision flags onto the {F1,F2,F3} one-hot result
  function automatic res_t res_code(input logic gt, input logic lt);
    return gt ? RES_GT : lt ? RES_LT : RES_EQ;
  endfunction
endpackage

// File: rtl/serial_compare_if.sv
// serial_compare_if: operand/start inputs and busy/done/flag outputs of the comparator
interface serial_compare_if;
  logic start;
  logic A;
  logic B;
  logic busy;
  logic done;
  logic F1;
  logic F2;
  logic F3;
  modport master (output start, A, B, input busy, done, F1, F2, F3);
  modport slave (input start, A, B, output busy, done, F1, F2, F3);
endinterface

// File: rtl/serial_compare_bit_cmp.sv
// bit_cmp: combinational one-bit magnitude relation of a against b
module bit_cmp
  import serial_compare_pkg::*;
(
  input  logic a,
  input  logic b,
  output rel_t rel
);
  assign rel = '{gt: a & ~b, eq: ~(a ^ b), lt: ~a & b};
endmodule

// File: rtl/serial_compare.sv
// serial_compare: MSB-first serial N-bit magnitude comparator with registered flags
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int N = 4
) (
  input logic clk,
  input logic rst,
  serial_compare_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 2);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic gt, lt, gt_n, lt_n;
  logic busy_r, busy_n, done_r, done_n;
  res_t res, res_n;
  rel_t rel;
  logic take, last_bit, keep, gt_u, lt_u;
  bit_cmp u_bit (.a(bus.A), .b(bus.B), .rel(rel));
  // start is honoured from IDLE and from DONE (back-to-back), never mid-run
  assign take = bus.start & (state != S_RUN);
  assign last_bit = (state == S_RUN) & (cnt == '0);
  // once a bit pair differs the decision is frozen; equal pairs never change it
  assign keep = gt | lt | rel.eq;
  assign gt_u = keep ? gt : rel.gt;
  assign lt_u = keep ? lt : rel.lt;
  // state and datapath registers, cleared asynchronously to abort any comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gt     <= 1'b0;
      lt     <= 1'b0;
      res    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gt     <= gt_n;
      lt     <= lt_n;
      res    <= res_n;
      busy_r <= busy_n;
      done_r <= done_n;
    end
  end
  // next state: RUN on an accepted start, DONE after the last bit, else IDLE
  always_comb begin
    state_n = take ? S_RUN : last_bit ? S_DONE : (state == S_RUN) ? S_RUN : S_IDLE;
  end
  // next register values; the MSB pair seeds the flags in the start cycle
  always_comb begin
    cnt_n  = take ? CNT_LOAD : (state == S_RUN && !last_bit) ? cnt - CW'(1) : '0;
    gt_n   = take ? rel.gt : (state == S_RUN) ? gt_u : 1'b0;
    lt_n   = take ? rel.lt : (state == S_RUN) ? lt_u : 1'b0;
    res_n  = last_bit ? res_code(gt_u, lt_u) : res;
    busy_n = take | ((state == S_RUN) & ~last_bit);
    done_n = last_bit;
  end
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign {bus.F1, bus.F2, bus.F3} = res;
endmodule

// File: tb/tb_serial_compare.sv
// tb_serial_compare: scoreboard bench for the serial magnitude comparator
module tb_serial_compare;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last = 3'b000;
  serial_compare_if bus ();
  serial_compare #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One comparison starting in the current cycle; optional stray start at cycle pulse_at
  task automatic drive_op(input logic [N-1:0] a, input logic [N-1:0] b, input int pulse_at, input string name);
    logic [2:0] e;
    bus.start = 1'b1;
    bus.A = a[N-1];
    bus.B = b[N-1];
    exp_q.push_back(a > b ? 3'b100 : a == b ? 3'b010 : 3'b001);
    for (int i = N - 2; i >= 0; i--) begin
      step();
      bus.start = (N - 1 - i == pulse_at);
      bus.A = a[i];
      bus.B = b[i];
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        failures++;
        $display("FAIL %s busy/done cycle %0d: got %b%b want 10", name, N - 1 - i, bus.busy, bus.done);
      end
      checks++;
      if ({bus.F1, bus.F2, bus.F3} !== last) begin
        failures++;
        $display("FAIL %s held flags cycle %0d: got %b want %b", name, N - 1 - i, {bus.F1, bus.F2, bus.F3}, last);
      end
    end
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done/busy cycle %0d: got %b%b want 10", name, N, bus.done, bus.busy);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty at done", name);
    end else begin
      e = exp_q.pop_front();
      if ({bus.F1, bus.F2, bus.F3} !== e) begin
        failures++;
        $display("FAIL %s result: got %b want %b", name, {bus.F1, bus.F2, bus.F3}, e);
      end
      last = e;
    end
  endtask

  task automatic idle(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      step();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.F1, bus.F2, bus.F3} !== last) begin
        failures++;
        $display("FAIL %s idle %0d: got busy=%b done=%b flags=%b want 0 0 %b", name, k, bus.busy, bus.done, {bus.F1, bus.F2, bus.F3}, last);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.A = 1'b0;
    bus.B = 1'b0;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.busy, bus.done, bus.F1, bus.F2, bus.F3} !== 5'b0) begin
      failures++;
      $display("FAIL reset outputs: got %b want 00000", {bus.busy, bus.done, bus.F1, bus.F2, bus.F3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_quiet();
    idle(10, "quiet");
  endtask

  task automatic test_gt();
    drive_op(4'b1010, 4'b0110, -1, "gt");
    idle(1, "gt_after");
  endtask

  task automatic test_back_to_back();
    drive_op(4'b0011, 4'b0011, -1, "eq");
    drive_op(4'b0100, 4'b0101, -1, "b2b_lt");
    idle(2, "b2b_after");
  endtask

  task automatic test_sticky();
    drive_op(4'b1000, 4'b0111, -1, "sticky");
    idle(1, "sticky_after");
  endtask

  task automatic test_start_ignored();
    drive_op(4'b0001, 4'b0000, 2, "start_ignored");
    idle(3, "single_done");
  endtask

  task automatic test_rst_abort();
    logic [N-1:0] a = 4'b1100;
    logic [N-1:0] b = 4'b1010;
    bus.start = 1'b1;
    bus.A = a[3];
    bus.B = b[3];
    step();
    bus.start = 1'b0;
    bus.A = a[2];
    bus.B = b[2];
    step();
    bus.A = a[1];
    bus.B = b[1];
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.F1, bus.F2, bus.F3} !== 5'b0) begin
      failures++;
      $display("FAIL rst_abort immediate: got %b want 00000", {bus.busy, bus.done, bus.F1, bus.F2, bus.F3});
    end
    @(posedge clk);
    #3 rst = 1'b0;
    last = 3'b000;
    idle(3, "rst_no_done");
    drive_op(4'b0110, 4'b0111, -1, "after_rst");
    idle(1, "after_rst_idle");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) drive_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), -1, "random");
    idle(2, "random_after");
  endtask

  initial begin
    test_reset();
    test_quiet();
    test_gt();
    test_back_to_back();
    test_sticky();
    test_start_ignored();
    test_rst_abort();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
